// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/decode/execute control sequencer for the phase-1 datapath.
// Drives T0..T6 control strobes for Ra <- Rb op Rc, with a HI/LO tail for MUL/DIV.
module alu_instr_sequencer #(
  parameter logic [4:0] MUL_OP  = 5'b01111,
  parameter logic [4:0] DIV_OP  = 5'b10000,
  parameter logic [4:0] NOP_OP  = 5'b11010,
  parameter logic [4:0] HALT_OP = 5'b11011
) (
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic        i_run,
  input  logic        i_mem_ready,
  input  logic [31:0] i_ir,
  output logic        o_pcout,
  output logic        o_zlowout,
  output logic        o_zhighout,
  output logic        o_mdrout,
  output logic        o_marin,
  output logic        o_pcin,
  output logic        o_mdrin,
  output logic        o_irin,
  output logic        o_yin,
  output logic        o_zlowin,
  output logic        o_zhighin,
  output logic        o_hiin,
  output logic        o_loin,
  output logic        o_incpc,
  output logic        o_read,
  output logic [4:0]  o_op_code,
  output logic [15:0] o_rin,
  output logic [15:0] o_rout,
  output logic [3:0]  o_state_out,
  output logic        o_instr_done,
  output logic        o_halted
);

  // state   | meaning
  // IDLE    | waiting for Run
  // T0      | PC -> MAR, PC+1 -> ZLo
  // T1      | memory read, wait for mem_ready, ZLo -> PC
  // T2      | MDR -> IR
  // T3      | decode; Rb -> Y (or NOP end / HALT branch)
  // T4      | Rc with Y through ALU into Z
  // T5      | ZLo -> Ra, or ZLo -> LO for MUL/DIV
  // T6      | ZHi -> HI for MUL/DIV
  // HALTED  | parked until Clear
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  state_t r_state;

  logic [4:0] w_op;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_muldiv;
  logic       w_unused;

  assign w_op     = i_ir[31:27];
  assign w_ra     = i_ir[26:23];
  assign w_rb     = i_ir[22:19];
  assign w_rc     = i_ir[18:15];
  assign w_muldiv = (w_op == MUL_OP) || (w_op == DIV_OP);
  assign w_unused = ^i_ir[14:0];

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_run) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   if (i_mem_ready) r_state <= S_T2;
        S_T2:   r_state <= S_T3;
        S_T3: begin
          if (w_op == HALT_OP)     r_state <= S_HALTED;
          else if (w_op == NOP_OP) r_state <= i_run ? S_T0 : S_IDLE;
          else                     r_state <= S_T4;
        end
        S_T4:   r_state <= S_T5;
        S_T5: begin
          if (w_muldiv) r_state <= S_T6;
          else          r_state <= i_run ? S_T0 : S_IDLE;
        end
        S_T6:     r_state <= i_run ? S_T0 : S_IDLE;
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes follow the current state so they cover the whole cycle, T1 also follows mem_ready.
  always_comb begin
    o_pcout      = 1'b0;
    o_zlowout    = 1'b0;
    o_zhighout   = 1'b0;
    o_mdrout     = 1'b0;
    o_marin      = 1'b0;
    o_pcin       = 1'b0;
    o_mdrin      = 1'b0;
    o_irin       = 1'b0;
    o_yin        = 1'b0;
    o_zlowin     = 1'b0;
    o_zhighin    = 1'b0;
    o_hiin       = 1'b0;
    o_loin       = 1'b0;
    o_incpc      = 1'b0;
    o_read       = 1'b0;
    o_op_code    = 5'd0;
    o_rin        = 16'd0;
    o_rout       = 16'd0;
    o_instr_done = 1'b0;
    o_halted     = 1'b0;
    case (r_state)
      S_T0: begin
        o_pcout  = 1'b1;
        o_marin  = 1'b1;
        o_incpc  = 1'b1;
        o_zlowin = 1'b1;
      end
      S_T1: begin
        o_read  = 1'b1;
        o_mdrin = 1'b1;
        if (i_mem_ready) begin
          o_zlowout = 1'b1;
          o_pcin    = 1'b1;
        end
      end
      S_T2: begin
        o_mdrout = 1'b1;
        o_irin   = 1'b1;
      end
      S_T3: begin
        if (w_op == NOP_OP) begin
          o_instr_done = 1'b1;
        end else if (w_op != HALT_OP) begin
          o_rout = 16'd1 << w_rb;
          o_yin  = 1'b1;
        end
      end
      S_T4: begin
        o_rout    = 16'd1 << w_rc;
        o_zlowin  = 1'b1;
        o_zhighin = w_muldiv;
        o_op_code = w_op;
      end
      S_T5: begin
        o_zlowout = 1'b1;
        if (w_muldiv) begin
          o_loin = 1'b1;
        end else begin
          o_rin        = 16'd1 << w_ra;
          o_instr_done = 1'b1;
        end
      end
      S_T6: begin
        o_zhighout   = 1'b1;
        o_hiin       = 1'b1;
        o_instr_done = 1'b1;
      end
      S_HALTED: o_halted = 1'b1;
      default: ;
    endcase
  end

  assign o_state_out = r_state;

endmodule
